spi_slave: RTL

Byte-oriented SPI slave (target) that pairs with spi_master on the same board-level SPI bus (sclk, mosi, miso, ss_n). It oversamples the asynchronous SPI pins in the system clock domain and supports all four CPOL/CPHA modes. Received words go out on a one-cycle valid strobe. Transmit words are accepted through a valid/ready handshake into a one-deep buffer. Multiple back-to-back words per ss_n frame are supported.

---
 rtl/spi_slave.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//
// Byte-oriented SPI target. The asynchronous pins (sclk, mosi, ss_n) are
// oversampled in the clk domain through a synchronizer chain. sclk edges are
// found by comparing the synchronized level against a one-cycle-delayed copy.
// All four CPOL/CPHA modes are supported. Mode is latched when the frame starts.
// Several words may be exchanged back to back inside one ss_n frame.
//
// Ports
//   clk, reset_n   system clock, synchronous active-low reset
//   cpol, cpha     SPI mode, latched when the frame starts
//   tx_data/valid  next word to send; accepted when tx_valid & tx_ready
//   tx_ready       one-deep transmit buffer is empty
//   rx_data        last complete received word (held)
//   rx_valid       one-cycle strobe when rx_data updates
//   busy           frame active
//   tx_underrun    one-cycle strobe when DEFAULT_TX is loaded (buffer empty)
//   frame_err      one-cycle strobe when ss_n rises in the middle of a word
//   sclk/mosi/ss_n SPI bus inputs (asynchronous)
//   miso, miso_oe  SPI data out (MSB first) and its pad enable
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_err,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    output logic                  miso_oe
);

    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_N-1:0]     sclk_sync_r;
    logic [SYNC_N-1:0]     mosi_sync_r;
    logic [SYNC_N-1:0]     ss_sync_r;
    logic [SYNC_N-1:0]     sync_vld_r;
    logic                  sclk_d_r;
    logic                  ss_d_r;
    logic                  ss_armed_r;

    // Frame state
    state_t                state_r;
    logic                  cpol_l_r;
    logic                  cpha_l_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  skip_shift_r;
    logic [DATA_WIDTH-1:0] rx_shift_r;
    logic [DATA_WIDTH-1:0] tx_shift_r;
    logic [DATA_WIDTH-1:0] tx_buf_r;
    logic                  tx_ready_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  rx_valid_r;
    logic                  busy_r;
    logic                  tx_underrun_r;
    logic                  frame_err_r;
    logic                  miso_r;
    logic                  miso_oe_r;

    // Decoded events
    logic                  sclk_s;
    logic                  mosi_s;
    logic                  ss_s;
    logic                  lead_s;
    logic                  trail_s;
    logic                  sample_s;
    logic                  shift_s;
    logic                  ss_fall_s;
    logic                  ss_rise_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] rx_word_s;
    logic [DATA_WIDTH-1:0] reload_word_s;
    logic                  reload_under_s;

    assign sclk_s    = sclk_sync_r[SYNC_N-1];
    assign mosi_s    = mosi_sync_r[SYNC_N-1];
    assign ss_s      = ss_sync_r[SYNC_N-1];
    // A falling ss_n only counts once a genuine high level has been seen
    // since reset, so a frame already in progress at reset is ignored.
    assign ss_fall_s = ss_armed_r & ss_d_r & ~ss_s;
    assign ss_rise_s = ~ss_d_r & ss_s;
    assign sample_s  = cpha_l_r ? trail_s : lead_s;
    assign shift_s   = cpha_l_r ? lead_s : trail_s;
    assign accept_s  = tx_valid & tx_ready_r;
    assign rx_word_s = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};

    assign tx_ready    = tx_ready_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign tx_underrun = tx_underrun_r;
    assign frame_err   = frame_err_r;
    assign miso        = miso_r;
    assign miso_oe     = miso_oe_r;

    // Synchronize the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_r <= {SYNC_N{1'b0}};
            mosi_sync_r <= {SYNC_N{1'b0}};
            ss_sync_r   <= {SYNC_N{1'b1}};
            sync_vld_r  <= {SYNC_N{1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_N-2:0], sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_N-2:0], mosi};
            ss_sync_r   <= {ss_sync_r[SYNC_N-2:0], ss_n};
            sync_vld_r  <= {sync_vld_r[SYNC_N-2:0], 1'b1};
        end
    end

    // Delayed copies for edge detection and the post-reset ss_n arming flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_d_r   <= 1'b0;
            ss_d_r     <= 1'b1;
            ss_armed_r <= 1'b0;
        end else begin
            sclk_d_r   <= sclk_s;
            ss_d_r     <= ss_s;
            ss_armed_r <= ss_armed_r | (sync_vld_r[SYNC_N-1] & ss_s);
        end
    end

    // Classify a synchronized sclk transition against the latched polarity
    always_comb begin
        lead_s  = 1'b0;
        trail_s = 1'b0;
        if (sclk_s != sclk_d_r) begin
            if (sclk_d_r == cpol_l_r) begin
                lead_s = 1'b1;
            end else begin
                trail_s = 1'b1;
            end
        end else begin
            lead_s  = 1'b0;
            trail_s = 1'b0;
        end
    end

    // Pick the next tx_shift word: buffered word, a word accepted this very
    // cycle, or DEFAULT_TX when nothing is available
    always_comb begin
        reload_word_s  = DEFAULT_TX;
        reload_under_s = 1'b0;
        if (!tx_ready_r) begin
            reload_word_s = tx_buf_r;
        end else if (tx_valid) begin
            reload_word_s = tx_data;
        end else begin
            reload_word_s  = DEFAULT_TX;
            reload_under_s = 1'b1;
        end
    end

    // Frame FSM: shift registers, bit counter, tx buffer and status strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            cpol_l_r      <= 1'b0;
            cpha_l_r      <= 1'b0;
            bit_cnt_r     <= {CNT_W{1'b0}};
            skip_shift_r  <= 1'b0;
            rx_shift_r    <= {DATA_WIDTH{1'b0}};
            tx_shift_r    <= {DATA_WIDTH{1'b0}};
            tx_buf_r      <= {DATA_WIDTH{1'b0}};
            tx_ready_r    <= 1'b1;
            rx_data_r     <= {DATA_WIDTH{1'b0}};
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            rx_valid_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;

            // Buffer write; a reload below may override tx_ready_r when the
            // accepted word goes straight into tx_shift.
            if (accept_s) begin
                tx_buf_r   <= tx_data;
                tx_ready_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (ss_fall_s) begin
                        state_r       <= ACTIVE;
                        busy_r        <= 1'b1;
                        miso_oe_r     <= 1'b1;
                        cpol_l_r      <= cpol;
                        cpha_l_r      <= cpha;
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        rx_shift_r    <= {DATA_WIDTH{1'b0}};
                        // In CPHA=1 the first leading edge would shift the
                        // freshly loaded MSB away, so it is skipped.
                        skip_shift_r  <= cpha;
                        tx_shift_r    <= reload_word_s;
                        tx_underrun_r <= reload_under_s;
                        tx_ready_r    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise_s) begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        miso_oe_r    <= 1'b0;
                        frame_err_r  <= (bit_cnt_r != {CNT_W{1'b0}});
                        bit_cnt_r    <= {CNT_W{1'b0}};
                        skip_shift_r <= 1'b0;
                    end else if (sample_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            rx_data_r     <= rx_word_s;
                            rx_valid_r    <= 1'b1;
                            rx_shift_r    <= rx_word_s;
                            bit_cnt_r     <= {CNT_W{1'b0}};
                            // The reload stands in for the next shift edge.
                            skip_shift_r  <= 1'b1;
                            tx_shift_r    <= reload_word_s;
                            tx_underrun_r <= reload_under_s;
                            tx_ready_r    <= 1'b1;
                        end else begin
                            rx_shift_r <= rx_word_s;
                            bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (shift_s) begin
                        if (skip_shift_r) begin
                            skip_shift_r <= 1'b0;
                        end else begin
                            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered miso: MSB of tx_shift while the frame is active
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miso_r <= 1'b0;
        end else begin
            miso_r <= busy_r & tx_shift_r[DATA_WIDTH-1];
        end
    end

endmodule
